// File: rtl/param_compressor.sv
// param_compressor: two-stage lane compressor. Each lane is tagged as zero,
// reference match, small signed value or raw. The block's encoded length is
// summed, and block / raw-lane statistics are kept.
//
// Handshake (both sides): a beat moves when valid && ready on the same rising
// edge. A producer holds valid and data until that happens. Ready never
// depends on the same side's valid.
module param_compressor #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 8,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int LW        = $clog2(NUM_DATA * (DATA_WIDTH + 2) + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             inValid,
    output logic                             inReady,
    input  logic                             bypass,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]   dataIn,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]   cprDataIn,
    output logic                             outValid,
    input  logic                             outReady,
    output logic [DATA_WIDTH*NUM_DATA-1:0]   dataOut,
    output logic [TAG_WIDTH*NUM_DATA-1:0]    tagOut,
    output logic [LW-1:0]                    cprLen,
    input  logic                             statClr,
    output logic [CNT_WIDTH-1:0]             blkCount,
    output logic [CNT_WIDTH-1:0]             rawCount
);

    localparam int BW = DATA_WIDTH * NUM_DATA;
    localparam int TW = TAG_WIDTH * NUM_DATA;
    localparam int PW = $clog2(NUM_DATA + 1);
    localparam int SW = CNT_WIDTH + PW;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                  s1_valid_q, s1_valid_d;
    logic [BW-1:0]         s1_word_q, s1_word_d;
    logic [TW-1:0]         s1_tag_q, s1_tag_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [BW-1:0]         data_out_q, data_out_d;
    logic [TW-1:0]         tag_out_q, tag_out_d;
    logic [LW-1:0]         cpr_len_q, cpr_len_d;
    logic [CNT_WIDTH-1:0]  blk_count_q, blk_count_d;
    logic [CNT_WIDTH-1:0]  raw_count_q, raw_count_d;

    logic                  s2_adv, s1_adv, in_fire, out_fire;
    logic [DATA_WIDTH-1:0] lane_word, lane_ref, lane_sext;
    logic [LW-1:0]         len_sum;
    logic [PW-1:0]         raw_lanes;
    logic [CNT_WIDTH:0]    blk_sum;
    logic [SW-1:0]         raw_sum;

    // Stage 2 moves when it is empty or being drained; stage 1 follows it.
    assign s2_adv   = !s2_valid_q || outReady;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign inReady  = s1_adv;
    assign in_fire  = inValid && s1_adv;
    assign out_fire = s2_valid_q && outReady;

    assign outValid = s2_valid_q;
    assign dataOut  = data_out_q;
    assign tagOut   = tag_out_q;
    assign cprLen   = cpr_len_q;
    assign blkCount = blk_count_q;
    assign rawCount = raw_count_q;

    // Stage 1: classify every lane of an accepted beat into tag + payload.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        s1_tag_d   = s1_tag_q;
        lane_word  = '0;
        lane_ref   = '0;
        lane_sext  = '0;
        if (s1_adv) s1_valid_d = in_fire;
        if (in_fire) begin
            for (int i = 0; i < NUM_DATA; i++) begin
                lane_word = dataIn[i*DATA_WIDTH +: DATA_WIDTH];
                lane_ref  = cprDataIn[i*DATA_WIDTH +: DATA_WIDTH];
                lane_sext = {{(DATA_WIDTH-LEN_WIDTH){lane_word[LEN_WIDTH-1]}},
                             lane_word[LEN_WIDTH-1:0]};
                if (bypass) begin
                    s1_tag_d[i*2 +: 2]                   = 2'b11;
                    s1_word_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_word;
                end else if (lane_word == '0) begin
                    s1_tag_d[i*2 +: 2]                   = 2'b00;
                    s1_word_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else if (lane_word == lane_ref) begin
                    s1_tag_d[i*2 +: 2]                   = 2'b01;
                    s1_word_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else if (lane_word == lane_sext) begin
                    s1_tag_d[i*2 +: 2]                   = 2'b10;
                    s1_word_d[i*DATA_WIDTH +: DATA_WIDTH] =
                        {{(DATA_WIDTH-LEN_WIDTH){1'b0}}, lane_word[LEN_WIDTH-1:0]};
                end else begin
                    s1_tag_d[i*2 +: 2]                   = 2'b11;
                    s1_word_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_word;
                end
            end
        end
    end

    // Stage 2: total encoded length from the stage-1 tags, then present the block.
    always_comb begin
        s2_valid_d = s2_valid_q;
        data_out_d = data_out_q;
        tag_out_d  = tag_out_q;
        cpr_len_d  = cpr_len_q;
        len_sum    = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            case (s1_tag_q[i*2 +: 2])
                2'b10:   len_sum = len_sum + LW'(2 + LEN_WIDTH);
                2'b11:   len_sum = len_sum + LW'(2 + DATA_WIDTH);
                default: len_sum = len_sum + LW'(2);
            endcase
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_out_d = s1_word_q;
                tag_out_d  = s1_tag_q;
                cpr_len_d  = len_sum;
            end
        end
    end

    // Statistics: saturating block and raw-lane counters, clear wins over a transfer.
    always_comb begin
        raw_lanes   = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            if (tag_out_q[i*2 +: 2] == 2'b11) raw_lanes = raw_lanes + PW'(1);
        end
        blk_sum     = {1'b0, blk_count_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
        raw_sum     = {{PW{1'b0}}, raw_count_q} + {{CNT_WIDTH{1'b0}}, raw_lanes};
        blk_count_d = blk_count_q;
        raw_count_d = raw_count_q;
        if (statClr) begin
            blk_count_d = '0;
            raw_count_d = '0;
        end else if (out_fire) begin
            blk_count_d = blk_sum[CNT_WIDTH] ? CNT_MAX : blk_sum[CNT_WIDTH-1:0];
            raw_count_d = (raw_sum > {{PW{1'b0}}, CNT_MAX}) ? CNT_MAX
                                                             : raw_sum[CNT_WIDTH-1:0];
        end
    end

    // All state registers; reset empties the pipe and zeroes every output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            data_out_q  <= '0;
            tag_out_q   <= '0;
            cpr_len_q   <= '0;
            blk_count_q <= '0;
            raw_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_word_q   <= s1_word_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            data_out_q  <= data_out_d;
            tag_out_q   <= tag_out_d;
            cpr_len_q   <= cpr_len_d;
            blk_count_q <= blk_count_d;
            raw_count_q <= raw_count_d;
        end
    end

endmodule

// File: tb/tb_param_compressor.sv
// Bench for param_compressor: transaction-level model with a scoreboard queue,
// directed literal cases, randomized traffic, plus two small-parameter instances.
module tb_param_compressor;

    localparam int DW = 32;
    localparam int ND = 8;
    localparam int BW = DW * ND;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic          inValid, bypass, outReady, statClr;
    logic          inReady, outValid;
    logic [BW-1:0] dataIn, cprDataIn, dataOut;
    logic [15:0]   tagOut;
    logic [8:0]    cprLen;
    logic [15:0]   blkCount, rawCount;

    param_compressor dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .bypass(bypass), .dataIn(dataIn), .cprDataIn(cprDataIn),
        .outValid(outValid), .outReady(outReady), .dataOut(dataOut),
        .tagOut(tagOut), .cprLen(cprLen), .statClr(statClr),
        .blkCount(blkCount), .rawCount(rawCount)
    );

    // ---------------- CNT_WIDTH = 2 instance ----------------
    logic          c_in_valid, c_in_ready, c_bypass, c_out_valid, c_out_ready, c_stat_clr;
    logic [BW-1:0] c_data_out;
    logic [15:0]   c_tag;
    logic [8:0]    c_len;
    logic [1:0]    c_blk, c_raw;

    param_compressor #(.CNT_WIDTH(2)) dut_c (
        .clk(clk), .reset(reset), .inValid(c_in_valid), .inReady(c_in_ready),
        .bypass(c_bypass), .dataIn(dataIn), .cprDataIn(cprDataIn),
        .outValid(c_out_valid), .outReady(c_out_ready), .dataOut(c_data_out),
        .tagOut(c_tag), .cprLen(c_len), .statClr(c_stat_clr),
        .blkCount(c_blk), .rawCount(c_raw)
    );

    // ---------------- NUM_DATA=3, DATA_WIDTH=16, LEN_WIDTH=4 instance ----------------
    logic        s_in_valid, s_in_ready, s_bypass, s_out_valid, s_out_ready, s_stat_clr;
    logic [47:0] s_data_in, s_ref_in, s_data_out;
    logic [5:0]  s_tag;
    logic [5:0]  s_len;
    logic [15:0] s_blk, s_raw;

    param_compressor #(.NUM_DATA(3), .DATA_WIDTH(16), .LEN_WIDTH(4)) dut_s (
        .clk(clk), .reset(reset), .inValid(s_in_valid), .inReady(s_in_ready),
        .bypass(s_bypass), .dataIn(s_data_in), .cprDataIn(s_ref_in),
        .outValid(s_out_valid), .outReady(s_out_ready), .dataOut(s_data_out),
        .tagOut(s_tag), .cprLen(s_len), .statClr(s_stat_clr),
        .blkCount(s_blk), .rawCount(s_raw)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q[$];
    logic [15:0]   exp_tag_q[$];
    logic [8:0]    exp_len_q[$];
    int            exp_raw_q[$];
    int            exp_blk = 0;
    int            exp_raw = 0;
    logic          hold_valid = 1'b0;
    logic [BW-1:0] hold_data;
    logic [15:0]   hold_tag;
    logic [8:0]    hold_len;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: per-lane rules on plain integers, length from lane counts.
    task automatic model(input logic [BW-1:0] d, input logic [BW-1:0] r, input logic byp,
                         output logic [BW-1:0] pd, output logic [15:0] tg,
                         output logic [8:0] len, output int raws);
        int n10, n11;
        logic [31:0] w;
        n10 = 0; n11 = 0; pd = '0; tg = '0;
        for (int i = 0; i < ND; i++) begin
            w = d[i*DW +: DW];
            if (byp) begin
                tg[i*2 +: 2] = 2'b11; pd[i*DW +: DW] = w; n11++;
            end else if (w == 32'd0) begin
                tg[i*2 +: 2] = 2'b00;
            end else if (w == r[i*DW +: DW]) begin
                tg[i*2 +: 2] = 2'b01;
            end else if ($signed(w) >= -128 && $signed(w) <= 127) begin
                tg[i*2 +: 2] = 2'b10; pd[i*DW +: DW] = w & 32'hFF; n10++;
            end else begin
                tg[i*2 +: 2] = 2'b11; pd[i*DW +: DW] = w; n11++;
            end
        end
        len  = 9'(2 * ND + 8 * n10 + 32 * n11);
        raws = n11;
    endtask

    // Compare process: sampled on the falling edge, predicts the next rising edge.
    always @(negedge clk) begin
        logic [BW-1:0] pd;
        logic [15:0]   tg;
        logic [8:0]    ln;
        int            rw;
        if (!reset) begin
            exp_q.delete(); exp_tag_q.delete(); exp_len_q.delete(); exp_raw_q.delete();
            exp_blk = 0; exp_raw = 0; hold_valid = 1'b0;
            chk("rst_out_valid", BW'(outValid), BW'(0));
            chk("rst_outputs", BW'({dataOut != 0, tagOut, cprLen}), BW'(0));
            chk("rst_counters", BW'({blkCount, rawCount}), BW'(0));
        end else begin
            chk("blk_count", BW'(blkCount), BW'(exp_blk));
            chk("raw_count", BW'(rawCount), BW'(exp_raw));
            if (hold_valid) begin
                chk("stall_valid", BW'(outValid), BW'(1));
                chk("stall_data", dataOut, hold_data);
                chk("stall_tag_len", BW'({tagOut, cprLen}), BW'({hold_tag, hold_len}));
            end
            hold_valid = outValid && !outReady;
            hold_data = dataOut; hold_tag = tagOut; hold_len = cprLen;
            if (outValid && outReady) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", tagOut);
                    rw = 0;
                end else begin
                    chk("out_data", dataOut, exp_q.pop_front());
                    chk("out_tag", BW'(tagOut), BW'(exp_tag_q.pop_front()));
                    chk("out_len", BW'(cprLen), BW'(exp_len_q.pop_front()));
                    rw = exp_raw_q.pop_front();
                end
                if (!statClr) begin
                    exp_blk = (exp_blk + 1 > 65535) ? 65535 : exp_blk + 1;
                    exp_raw = (exp_raw + rw > 65535) ? 65535 : exp_raw + rw;
                end
            end
            if (statClr) begin
                exp_blk = 0; exp_raw = 0;
            end
            if (inValid && inReady) begin
                model(dataIn, cprDataIn, bypass, pd, tg, ln, rw);
                exp_q.push_back(pd); exp_tag_q.push_back(tg);
                exp_len_q.push_back(ln); exp_raw_q.push_back(rw);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_block(input logic [BW-1:0] d, input logic [BW-1:0] r, input logic byp);
        logic ok;
        int   n;
        inValid = 1'b1; dataIn = d; cprDataIn = r; bypass = byp;
        ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = inReady;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=%0d required=accept", n);
        end
    endtask

    task automatic gen_block(output logic [BW-1:0] d, output logic [BW-1:0] r);
        logic [31:0] w, rf;
        for (int i = 0; i < ND; i++) begin
            rf = $urandom;
            case ($urandom_range(0, 4))
                0: w = 32'd0;
                1: w = rf;
                2: w = {{24{1'b0}}, 8'($urandom)} - 32'd128;
                3: w = $urandom;
                default: case ($urandom_range(0, 3))
                    0: w = 32'h0000_0080;
                    1: w = 32'hFFFF_FF7F;
                    2: w = 32'h0000_007F;
                    default: w = 32'hFFFF_FF80;
                endcase
            endcase
            d[i*DW +: DW] = w;
            r[i*DW +: DW] = rf;
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [BW-1:0] d0, r0, dd, rr;
    initial begin
        reset = 1'b1;
        inValid = 0; bypass = 0; outReady = 1; statClr = 0; dataIn = '0; cprDataIn = '0;
        c_in_valid = 0; c_bypass = 1; c_out_ready = 1; c_stat_clr = 0;
        s_in_valid = 0; s_bypass = 0; s_out_ready = 1; s_stat_clr = 0;
        s_data_in = '0; s_ref_in = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", BW'(inReady), BW'(1));

        // Literal block with known encoding.
        d0 = {32'hFFFFFFFF, 32'h0, 32'h0, 32'h12345678,
              32'hFFFFFF80, 32'h0000007F, 32'hDEADBEEF, 32'h0};
        r0 = {8{32'hDEADBEEF}};
        inValid = 1; dataIn = d0; cprDataIn = r0; bypass = 0;
        @(posedge clk); #1;
        inValid = 0;
        chk("lat_not_yet", BW'(outValid), BW'(0));
        @(posedge clk); #1;
        chk("lat_valid", BW'(outValid), BW'(1));
        chk("lit_tag", BW'(tagOut), BW'(16'h83A4));
        chk("lit_data", dataOut, {32'hFF, 32'h0, 32'h0, 32'h12345678,
                                  32'h80, 32'h7F, 32'h0, 32'h0});
        chk("lit_len", BW'(cprLen), BW'(72));

        // Same block in bypass mode.
        inValid = 1; bypass = 1;
        @(posedge clk); #1;
        inValid = 0; bypass = 0;
        @(posedge clk); #1;
        chk("byp_tag", BW'(tagOut), BW'(16'hFFFF));
        chk("byp_data", dataOut, d0);
        chk("byp_len", BW'(cprLen), BW'(272));
        repeat (2) @(posedge clk); #1;

        // Four back-to-back blocks into a stalled output.
        outReady = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    gen_block(dd, rr);
                    dd[31:0] = 32'h1000_0000 + k;
                    send_block(dd, rr, 1'b0);
                    if (k == 1) chk("stall_in_ready", BW'(inReady), BW'(0));
                end
                inValid = 0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 outReady = 1;
            end
        join
        repeat (8) @(posedge clk); #1;
        chk("stall_drain", BW'(exp_q.size()), BW'(0));

        // Randomized traffic with random back-pressure and clears.
        for (int cyc = 0; cyc < 400; cyc++) begin
            gen_block(dd, rr);
            inValid   = ($urandom_range(0, 3) != 0);
            outReady  = ($urandom_range(0, 3) != 0);
            bypass    = ($urandom_range(0, 7) == 0);
            statClr   = ($urandom_range(0, 29) == 0);
            dataIn    = dd;
            cprDataIn = rr;
            @(posedge clk); #1;
        end
        inValid = 0; statClr = 0; outReady = 1;
        repeat (6) @(posedge clk); #1;
        chk("random_drain", BW'(exp_q.size()), BW'(0));

        // Reset while two blocks are in flight.
        outReady = 0;
        gen_block(dd, rr); send_block(dd, rr, 1'b0);
        gen_block(dd, rr); send_block(dd, rr, 1'b0);
        inValid = 0;
        #2 reset = 1'b0;
        #1 chk("midop_rst_valid", BW'(outValid), BW'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; outReady = 1;
        @(posedge clk); #1;
        chk("midop_in_ready", BW'(inReady), BW'(1));
        repeat (5) @(posedge clk); #1;
        chk("midop_no_stale", BW'(outValid), BW'(0));

        // Saturating counters (CNT_WIDTH = 2), bypass makes every lane raw.
        c_in_valid = 1;
        repeat (5) @(posedge clk);
        #1 c_in_valid = 0;
        repeat (4) @(posedge clk); #1;
        chk("sat_blk", BW'(c_blk), BW'(3));
        chk("sat_raw", BW'(c_raw), BW'(3));
        c_in_valid = 1;
        @(posedge clk); #1 c_in_valid = 0;
        @(posedge clk); #1;
        chk("clr_pre_valid", BW'(c_out_valid), BW'(1));
        c_stat_clr = 1;
        @(posedge clk); #1 c_stat_clr = 0;
        chk("clr_blk", BW'(c_blk), BW'(0));
        chk("clr_raw", BW'(c_raw), BW'(0));
        chk("clr_transferred", BW'(c_out_valid), BW'(0));

        // Narrow instance: three 16-bit lanes of 0x0007.
        s_data_in = {3{16'h0007}}; s_in_valid = 1;
        @(posedge clk); #1 s_in_valid = 0;
        @(posedge clk); #1;
        chk("small_valid", BW'(s_out_valid), BW'(1));
        chk("small_tag", BW'(s_tag), BW'(6'b101010));
        chk("small_len", BW'(s_len), BW'(18));
        chk("small_data", BW'(s_data_out), BW'({3{16'h0007}}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
